// File: rtl/pa_mean_ctrl.sv
// Frame-mean sequencer: sums a framed sample stream, launches sum/count on the
// shared divider and reports the quotient (or a timeout) as the frame mean.
module pa_mean_ctrl #(
    parameter int SIZE_DATA   = 32,
    parameter int SIZE_CNT    = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_valid,
    input  logic [SIZE_DATA-1:0] i_data,
    input  logic                 i_last,
    output logic                 o_ready,
    output logic                 o_div_start,
    output logic [SIZE_DATA-1:0] o_div_dividend,
    output logic [SIZE_DATA-1:0] o_div_divisor,
    input  logic [SIZE_DATA-1:0] i_div_quotient,
    input  logic                 i_div_done,
    output logic [SIZE_DATA-1:0] o_mean,
    output logic                 o_mean_valid,
    output logic                 o_err_ovf,
    output logic                 o_err_to,
    output logic                 o_busy,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    // Counter value whose accept brings cnt to its all-ones limit.
    localparam logic [SIZE_CNT-1:0] CNT_CLOSE = {{(SIZE_CNT-1){1'b1}}, 1'b0};

    state_t               state;
    state_t               state_nxt;
    logic [SIZE_DATA-1:0] sum;
    logic [SIZE_CNT-1:0]  cnt;
    logic                 ovf_frame;
    logic [TO_W-1:0]      to_cnt;
    logic [SIZE_DATA:0]   sum_ext;
    logic                 accept;
    logic                 closing;
    logic                 leave_wait;

    // Handshake: a sample transfers on a rising edge where i_valid and o_ready
    // are both high; o_ready is only high in ACC and never while i_clear is set.
    always_comb begin
        state_nxt   = state;
        o_ready     = 1'b0;
        o_div_start = 1'b0;
        accept      = 1'b0;
        closing     = 1'b0;
        leave_wait  = 1'b0;
        sum_ext     = {1'b0, sum} + {1'b0, i_data};
        case (state)
            ST_ACC: begin
                o_ready = ~i_clear;
                accept  = i_valid & ~i_clear;
                closing = accept & (i_last | (cnt == CNT_CLOSE));
                if (closing) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                o_div_start = ~i_clear;
                state_nxt   = ST_WAIT;
            end
            ST_WAIT: begin
                leave_wait = i_div_done | (to_cnt == TO_LAST);
                if (leave_wait) begin
                    state_nxt = ST_ACC;
                end
            end
            default: state_nxt = ST_ACC;
        endcase
        if (i_clear) begin
            state_nxt = ST_ACC;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame accumulation; everything is wiped on the way back into ACC.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sum       <= '0;
            cnt       <= '0;
            ovf_frame <= 1'b0;
            to_cnt    <= '0;
        end else if (i_clear || (state != ST_ACC && state_nxt == ST_ACC)) begin
            sum       <= '0;
            cnt       <= '0;
            ovf_frame <= 1'b0;
            to_cnt    <= '0;
        end else if (accept) begin
            sum       <= sum_ext[SIZE_DATA-1:0];
            cnt       <= cnt + SIZE_CNT'(1);
            ovf_frame <= ovf_frame | sum_ext[SIZE_DATA];
        end else if (state == ST_WAIT) begin
            to_cnt    <= to_cnt + TO_W'(1);
        end
    end

    // Result reporting: done wins over timeout; an abort reports nothing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mean       <= '0;
            o_mean_valid <= 1'b0;
            o_err_ovf    <= 1'b0;
            o_err_to     <= 1'b0;
        end else begin
            o_mean_valid <= 1'b0;
            if (state == ST_WAIT && !i_clear) begin
                if (i_div_done) begin
                    o_mean       <= i_div_quotient;
                    o_err_ovf    <= ovf_frame;
                    o_err_to     <= 1'b0;
                    o_mean_valid <= 1'b1;
                end else if (to_cnt == TO_LAST) begin
                    o_err_ovf    <= ovf_frame;
                    o_err_to     <= 1'b1;
                    o_mean_valid <= 1'b1;
                end
            end
        end
    end

    assign o_div_dividend = sum;
    assign o_div_divisor  = SIZE_DATA'(cnt);
    assign o_busy         = (state != ST_ACC);
    assign o_dbg_state    = state;

endmodule
